// File: rtl/channel_frame_packer.sv
// channel_frame_packer
//   Drains 120-bit words from a first-word-fall-through FIFO and packs them
//   into Ethernet-style frames on an 8-bit AXI-stream:
//     16-byte header (D_MAC, S_MAC, ETHERTYPE, CHANNEL_ID, N)
//     N payload words, 15 bytes each, MSB first
//     zero padding up to a 60-byte minimum frame
//   A frame starts when the FIFO reaches counter_th words, or when data has
//   sat in the FIFO for idle_counter_number_th cycles without a start.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   D_MAC_add, S_MAC_add        MAC addresses, latched at frame start
//   counter_th                  occupancy threshold that starts a frame
//   idle_counter_number_th      idle timeout in cycles (0 = disabled)
//   data_tran_stop              blocks new frame starts
//   channel_data/_counter/_fifo_empty   FIFO head word, occupancy, empty
//   channel_data_read           one-cycle pop, on the last byte of each word
//   tx_axis_fifo_*              byte stream out (tdata/tvalid/tlast, tready in)
//   busy                        frame in progress
//   frame_count                 completed frames, wraps
module channel_frame_packer #(
   parameter logic [7:0]  CHANNEL_ID = 8'h00,
   parameter int          MAX_WORDS  = 96,
   parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [47:0]  D_MAC_add,
   input  logic [47:0]  S_MAC_add,
   input  logic [9:0]   counter_th,
   input  logic [15:0]  idle_counter_number_th,
   input  logic         data_tran_stop,
   input  logic [119:0] channel_data,
   input  logic [9:0]   channel_data_counter,
   input  logic         channel_fifo_empty,
   output logic         channel_data_read,
   output logic [7:0]   tx_axis_fifo_tdata,
   output logic         tx_axis_fifo_tvalid,
   input  logic         tx_axis_fifo_tready,
   output logic         tx_axis_fifo_tlast,
   output logic         busy,
   output logic [15:0]  frame_count
);

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAD} state_t;

   state_t       state_q;
   logic [3:0]   hcnt_q;      // header byte index
   logic [3:0]   wbyte_q;     // byte index within the current word
   logic [7:0]   n_q;         // words in this frame
   logic [7:0]   words_q;     // words left, including the current one
   logic [7:0]   pad_q;       // pad bytes left, including the current one
   logic [47:0]  dmac_q, smac_q;
   logic [15:0]  idle_q, idle_d;
   logic [15:0]  fcnt_q;
   logic         tvalid_q, tlast_q, busy_q;

   logic [9:0]   th_eff;
   logic         start, xfer;
   logic [7:0]   n_start, pad_n;
   logic [127:0] hdr_w;

   assign th_eff  = (counter_th == 10'd0) ? 10'd1 : counter_th;
   assign start   = !data_tran_stop && !channel_fifo_empty &&
                    ((channel_data_counter >= th_eff) ||
                     ((idle_counter_number_th != 16'd0) &&
                      (idle_q == idle_counter_number_th)));
   assign n_start = (channel_data_counter > 10'(MAX_WORDS)) ? 8'(MAX_WORDS)
                                                             : channel_data_counter[7:0];
   assign xfer    = tvalid_q && tx_axis_fifo_tready;
   assign hdr_w   = {dmac_q, smac_q, ETHERTYPE, CHANNEL_ID, n_q};

   // Only frames of 0..2 words fall short of the 60-byte minimum.
   always_comb begin
      case (n_q)
         8'd0:    pad_n = 8'd44;
         8'd1:    pad_n = 8'd29;
         8'd2:    pad_n = 8'd14;
         default: pad_n = 8'd0;
      endcase
   end

   always_comb begin
      idle_d = idle_q;
      if (channel_fifo_empty)     idle_d = 16'd0;
      else if (idle_q != 16'hFFFF) idle_d = idle_q + 16'd1;
   end

   // Payload bytes come straight off the FWFT head, so the pop can land on
   // the same edge that accepts the word's last byte and the next word's
   // first byte is already on the bus afterwards. The head only moves on a
   // pop, so tdata stays stable across stalls.
   always_comb begin
      tx_axis_fifo_tdata = 8'h00;
      case (state_q)
         HDR:     tx_axis_fifo_tdata = hdr_w[8*(15-int'(hcnt_q)) +: 8];
         PAYLOAD: tx_axis_fifo_tdata = channel_data[8*(14-int'(wbyte_q)) +: 8];
         default: tx_axis_fifo_tdata = 8'h00;
      endcase
   end

   // Gated by reset so an abandoned frame never pops.
   assign channel_data_read = !reset && xfer && (state_q == PAYLOAD) && (wbyte_q == 4'd14);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         hcnt_q   <= '0;
         wbyte_q  <= '0;
         n_q      <= '0;
         words_q  <= '0;
         pad_q    <= '0;
         dmac_q   <= '0;
         smac_q   <= '0;
         idle_q   <= '0;
         fcnt_q   <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else if (state_q == IDLE) begin
         if (start) begin
            state_q  <= HDR;
            hcnt_q   <= '0;
            n_q      <= n_start;
            dmac_q   <= D_MAC_add;
            smac_q   <= S_MAC_add;
            idle_q   <= '0;
            tvalid_q <= 1'b1;
            busy_q   <= 1'b1;
            tlast_q  <= 1'b0;
         end else begin
            idle_q <= idle_d;
         end
      end else if (xfer) begin
         if (tlast_q) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            fcnt_q   <= fcnt_q + 16'd1;
         end else begin
            case (state_q)
               HDR: begin
                  if (hcnt_q == 4'd15) begin
                     if (n_q == 8'd0) begin
                        state_q <= PAD;
                        pad_q   <= pad_n;
                        tlast_q <= (pad_n == 8'd1);
                     end else begin
                        state_q <= PAYLOAD;
                        wbyte_q <= '0;
                        words_q <= n_q;
                     end
                  end else begin
                     hcnt_q <= hcnt_q + 4'd1;
                  end
               end
               PAYLOAD: begin
                  if (wbyte_q == 4'd14) begin
                     // Last word without pad ends via tlast, so reaching
                     // here on the last word always means padding follows.
                     wbyte_q <= '0;
                     if (words_q == 8'd1) begin
                        state_q <= PAD;
                        pad_q   <= pad_n;
                        tlast_q <= (pad_n == 8'd1);
                     end else begin
                        words_q <= words_q - 8'd1;
                     end
                  end else begin
                     wbyte_q <= wbyte_q + 4'd1;
                     tlast_q <= (wbyte_q == 4'd13) && (words_q == 8'd1) && (pad_n == 8'd0);
                  end
               end
               PAD: begin
                  pad_q   <= pad_q - 8'd1;
                  tlast_q <= (pad_q == 8'd2);
               end
               default: ;
            endcase
         end
      end
   end

   assign tx_axis_fifo_tvalid = tvalid_q;
   assign tx_axis_fifo_tlast  = tlast_q;
   assign busy                = busy_q;
   assign frame_count         = fcnt_q;

endmodule

// File: tb/tb_channel_frame_packer.sv
// Directed bench for channel_frame_packer: a behavioural FWFT FIFO feeds the
// block, expected frames are queued when words are loaded, and a monitor
// pops and compares every accepted byte.
module tb_channel_frame_packer;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic [47:0]  dmac, smac;
   logic [9:0]   counter_th;
   logic [15:0]  idle_th;
   logic         stop;
   logic [119:0] cdata;
   logic [9:0]   ccount;
   logic         cempty, cread;
   logic [7:0]   tdata;
   logic         tvalid, tready, tlast, busy;
   logic [15:0]  fcount;

   always #5 clk = ~clk;

   channel_frame_packer dut (
      .clk                    (clk),
      .reset                  (reset),
      .D_MAC_add              (dmac),
      .S_MAC_add              (smac),
      .counter_th             (counter_th),
      .idle_counter_number_th (idle_th),
      .data_tran_stop         (stop),
      .channel_data           (cdata),
      .channel_data_counter   (ccount),
      .channel_fifo_empty     (cempty),
      .channel_data_read      (cread),
      .tx_axis_fifo_tdata     (tdata),
      .tx_axis_fifo_tvalid    (tvalid),
      .tx_axis_fifo_tready    (tready),
      .tx_axis_fifo_tlast     (tlast),
      .busy                   (busy),
      .frame_count            (fcount)
   );

   // FWFT FIFO model: pop sampled mid-cycle, applied on the next edge
   logic [119:0] mem [0:1023];
   logic [9:0]   wr_ptr = '0;
   logic [9:0]   rd_ptr = '0;
   logic         pop_pend = 1'b0;
   int           pops = 0;

   assign cdata  = mem[rd_ptr];
   assign ccount = wr_ptr - rd_ptr;
   assign cempty = (wr_ptr == rd_ptr);

   always @(negedge clk) pop_pend = cread;
   always @(posedge clk) begin
      if (pop_pend) begin
         rd_ptr <= rd_ptr + 10'd1;
         pops   <= pops + 1;
      end
   end

   int checks = 0, errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard
   exp_t        exp_q[$];
   int          acc_cnt = 0, frames_seen = 0, last_len = 0;
   logic        stall_v = 1'b0;
   logic [7:0]  hold_d = '0;
   logic        hold_l = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stall_v = 1'b0;
      end else begin
         if (stall_v) begin
            check("hold_tvalid", 32'(tvalid), 32'd1);
            check("hold_tdata", 32'(tdata), 32'(hold_d));
            check("hold_tlast", 32'(tlast), 32'(hold_l));
         end
         if (tvalid && tready) begin
            check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("tdata", 32'(tdata), 32'(e.d));
               check("tlast", 32'(tlast), 32'(e.l));
            end
            acc_cnt++;
            if (tlast) begin
               frames_seen++;
               last_len = acc_cnt;
               acc_cnt  = 0;
            end
         end
         stall_v = tvalid && !tready;
         hold_d  = tdata;
         hold_l  = tlast;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_n(input int n);
      logic [127:0] r;
      for (int i = 0; i < n; i++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         mem[wr_ptr] = r[119:0];
         wr_ptr = wr_ptr + 10'd1;
      end
   endtask

   task automatic expect_frame(input int n, input logic [9:0] base);
      logic [127:0] hdr;
      logic [119:0] w;
      exp_t         e;
      int           len;
      hdr = {dmac, smac, 16'h88B5, 8'h00, 8'(n)};
      len = (16 + 15*n < 60) ? 60 : 16 + 15*n;
      for (int i = 0; i < len; i++) begin
         if (i < 16) begin
            e.d = hdr[127-8*i -: 8];
         end else if (i < 16 + 15*n) begin
            w   = mem[base + 10'((i-16)/15)];
            e.d = w[119-8*((i-16)%15) -: 8];
         end else begin
            e.d = 8'h00;
         end
         e.l = (i == len-1);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_frames(input int target, input int budget, input bit rnd);
      int c = 0;
      while (frames_seen < target && c < budget) begin
         tick();
         c++;
         if (rnd) tready = 1'($urandom_range(0, 1));
      end
      tready = 1'b1;
      check("frame_done_in_time", 32'(frames_seen >= target), 32'd1);
   endtask

   initial begin
      logic [9:0] base;
      int         cyc;
      logic       seen;

      reset = 1'b1; stop = 1'b1; tready = 1'b1;
      counter_th = 10'd3; idle_th = 16'd0;
      dmac = 48'h0A1B2C3D4E5F; smac = 48'h665544332211;
      for (int i = 0; i < 1024; i++) mem[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_tlast", 32'(tlast), 32'd0);
      check("rst_tdata", 32'(tdata), 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fcount", 32'(fcount), 32'd0);
      check("rst_read", 32'(cread), 32'd0);
      tick();
      reset = 1'b0; stop = 1'b0;

      // S1: threshold start, N=3, 61 bytes
      tick();
      base = rd_ptr;
      push_n(3);
      expect_frame(3, base);
      @(posedge clk); @(negedge clk);
      check("s1_lat_tvalid", 32'(tvalid), 32'd1);
      check("s1_lat_tdata", 32'(tdata), 32'h0A);
      check("s1_lat_busy", 32'(busy), 32'd1);
      tick();
      dmac = 48'hC0FFEE123456; smac = 48'hDEADBEEF0001;   // must not affect frame
      wait_frames(1, 300, 1'b0);
      check("s1_len", 32'(last_len), 32'd61);
      check("s1_pops", 32'(pops), 32'd3);
      check("s1_fcount", 32'(fcount), 32'd1);
      @(negedge clk);
      check("s1_idle_tvalid", 32'(tvalid), 32'd0);
      check("s1_idle_busy", 32'(busy), 32'd0);

      // S2: idle-timeout start, N=1 with 29 pad bytes
      tick();
      counter_th = 10'd10; idle_th = 16'd100;
      base = rd_ptr;
      push_n(1);
      expect_frame(1, base);
      cyc = 0; seen = 1'b0;
      while (!seen && cyc < 300) begin
         @(posedge clk); cyc++;
         @(negedge clk); seen = tvalid;
      end
      check("s2_start_delay", 32'(cyc), 32'd101);
      wait_frames(2, 300, 1'b0);
      check("s2_len", 32'(last_len), 32'd60);
      check("s2_pops", 32'(pops), 32'd4);
      check("s2_fcount", 32'(fcount), 32'd2);
      idle_th = 16'd0;

      // S3: 200 words, two back-to-back MAX_WORDS frames
      tick();
      stop = 1'b1; counter_th = 10'd100;
      base = rd_ptr;
      push_n(200);
      expect_frame(96, base);
      expect_frame(96, base + 10'd96);
      tick();
      stop = 1'b0;
      wait_frames(4, 4000, 1'b0);
      check("s3_len", 32'(last_len), 32'd1456);
      check("s3_pops", 32'(pops), 32'd196);
      check("s3_fcount", 32'(fcount), 32'd4);
      check("s3_left", 32'(ccount), 32'd8);

      // S3b: drain the remaining 8 words
      counter_th = 10'd8;
      expect_frame(8, rd_ptr);
      wait_frames(5, 400, 1'b0);
      check("s3b_len", 32'(last_len), 32'd136);
      check("s3b_pops", 32'(pops), 32'd204);

      // S4: random backpressure, N=2
      tick();
      counter_th = 10'd2;
      base = rd_ptr;
      push_n(2);
      expect_frame(2, base);
      wait_frames(6, 2000, 1'b1);
      check("s4_len", 32'(last_len), 32'd60);
      check("s4_pops", 32'(pops), 32'd206);
      check("s4_fcount", 32'(fcount), 32'd6);

      // S5: reset at byte 20 of an N=5 frame
      tick();
      counter_th = 10'd5;
      base = rd_ptr;
      push_n(5);
      expect_frame(5, base);
      cyc = 0;
      while (acc_cnt != 19 && cyc < 200) begin tick(); cyc++; end
      check("s5_at_byte20", 32'(acc_cnt), 32'd19);
      reset = 1'b1; tready = 1'b0;
      @(posedge clk); @(negedge clk);
      check("s5_rst_tvalid", 32'(tvalid), 32'd0);
      check("s5_rst_busy", 32'(busy), 32'd0);
      check("s5_rst_fcount", 32'(fcount), 32'd0);
      check("s5_rst_pops", 32'(pops), 32'd206);
      check("s5_rst_read", 32'(cread), 32'd0);
      exp_q.delete();
      acc_cnt = 0;
      expect_frame(5, base);
      tick();
      reset = 1'b0; tready = 1'b1;
      @(posedge clk); @(negedge clk);
      check("s5_restart_tvalid", 32'(tvalid), 32'd1);
      check("s5_restart_tdata", 32'(tdata), 32'(dmac[47:40]));
      wait_frames(7, 300, 1'b0);
      check("s5_len", 32'(last_len), 32'd91);
      check("s5_pops", 32'(pops), 32'd211);
      check("s5_fcount", 32'(fcount), 32'd1);

      // S6: data_tran_stop blocks starts but never truncates a frame
      tick();
      stop = 1'b1; counter_th = 10'd2;
      base = rd_ptr;
      push_n(3);
      repeat (20) tick();
      @(negedge clk);
      check("s6_blocked_tvalid", 32'(tvalid), 32'd0);
      check("s6_blocked_busy", 32'(busy), 32'd0);
      check("s6_blocked_pops", 32'(pops), 32'd211);
      tick();
      expect_frame(3, base);
      stop = 1'b0;
      cyc = 0;
      while (acc_cnt < 10 && cyc < 100) begin tick(); cyc++; end
      stop = 1'b1;
      wait_frames(8, 300, 1'b0);
      check("s6_len", 32'(last_len), 32'd61);
      check("s6_pops", 32'(pops), 32'd214);
      check("s6_fcount", 32'(fcount), 32'd2);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      repeat (5) tick();
      @(negedge clk);
      check("end_idle_tvalid", 32'(tvalid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/channel_frame_packer.md
CHANNEL_FRAME_PACKER -- requirements
Module: channel_frame_packer

Interface
REQ-001 Parameters SHALL be: CHANNEL_ID, default 8'h00, channel number placed in the frame header; MAX_WORDS, default 96, maximum FIFO words per frame (1..255); ETHERTYPE, default 16'h88B5, frame type field.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, 160 MHz domain
- reset  in  1  synchronous, active-high
- D_MAC_add  in  48  destination MAC
- S_MAC_add  in  48  source MAC
- counter_th  in  10  FIFO-depth threshold that starts a frame
- idle_counter_number_th  in  16  idle timeout in clk cycles; 0 disables the timeout
- data_tran_stop  in  1  blocks the start of new frames
- channel_data  in  120  first-word-fall-through FIFO head word
- channel_data_counter  in  10  FIFO occupancy
- channel_fifo_empty  in  1  FIFO empty
- channel_data_read  out  1  one-cycle FIFO pop
- tx_axis_fifo_tdata  out  8  stream byte
- tx_axis_fifo_tvalid  out  1  byte valid
- tx_axis_fifo_tready  in  1  sink ready
- tx_axis_fifo_tlast  out  1  last byte of frame
- busy  out  1  a frame is in progress
- frame_count  out  16  frames completed, wraps at 16'hFFFF to 0
REQ-003 The block SHALL use one clock, clk, and a synchronous active-high reset, reset.

Function
REQ-004 The block SHALL implement an FSM with the states IDLE, HDR, PAYLOAD, PAD.
REQ-005 In IDLE, a frame SHALL start when data_tran_stop=0 and channel_fifo_empty=0, and either of the following holds:
- channel_data_counter >= max(counter_th,1), or
- the idle counter equals idle_counter_number_th, with idle_counter_number_th != 0.
REQ-006 The idle counter SHALL increment in IDLE while the FIFO is non-empty and no start condition holds, saturate at 16'hFFFF, and clear on frame start or when the FIFO is empty.
REQ-007 On start, the block SHALL latch N = min(channel_data_counter, MAX_WORDS), D_MAC_add and S_MAC_add. Mid-frame changes to these inputs SHALL have no effect.
REQ-008 Latency: if the start condition is true at cycle k, then at cycle k+1 tvalid=1, tdata=D_MAC_add[47:40] and busy=1.
REQ-009 HDR SHALL emit 16 bytes, MSB first, in this order:
- D_MAC (6 bytes)
- S_MAC (6 bytes)
- ETHERTYPE (2 bytes)
- CHANNEL_ID (1 byte)
- N[7:0] (1 byte)
REQ-010 PAYLOAD SHALL emit each word as 15 bytes, channel_data[119:112] first and [7:0] last.
REQ-011 channel_data_read SHALL pulse for exactly one cycle when the 15th byte of a word is accepted, giving exactly N pops per frame.
REQ-012 A byte SHALL be transferred only when tvalid && tready. While tready=0, tdata, tvalid and tlast SHALL hold unchanged, and no pop SHALL occur.
REQ-013 If 16+15N < 60, PAD SHALL emit 8'h00 bytes until the frame reaches 60 bytes (N=1: 29 pad bytes; N=2: 14 pad bytes). Otherwise PAD SHALL be skipped.
REQ-014 tlast SHALL be 1 only on the final byte of the frame (last pad byte, or last payload byte when there is no pad).
REQ-015 After the tlast byte is accepted:
- frame_count SHALL increment;
- the FSM SHALL return to IDLE;
- tvalid and busy SHALL be 0 for at least one cycle before the next frame starts.
REQ-016 data_tran_stop asserted mid-frame SHALL NOT truncate the frame. It only blocks new starts.
REQ-017 channel_fifo_empty=1 in PAYLOAD is an upstream error. The block SHALL continue emitting channel_data unchanged and SHALL NOT stall.
REQ-018 frame_count SHALL wrap from 16'hFFFF to 16'h0000.

Reset
REQ-019 While reset=1 at a clk edge, the block SHALL set:
- FSM to IDLE
- tvalid=0, tlast=0, tdata=8'h00
- channel_data_read=0, busy=0
- frame_count=0
- idle counter=0, all latched values cleared
REQ-020 Reset asserted mid-frame SHALL abandon the frame: tvalid=0 on the next cycle, no further pops, and frame_count not incremented.
REQ-021 After reset is released, the earliest frame start SHALL be evaluated in the first cycle with reset=0.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- counter_th=3, FIFO loaded with 3 words, tready=1 -> 61-byte frame: 16 header bytes ending 8'h00,8'h03, then 45 payload bytes; 3 pops; tlast on byte 61; frame_count=1.
- counter_th=10, idle_th=100, 1 word -> start 100 cycles after the FIFO goes non-empty; frame of 16+15+29=60 bytes, last 29 bytes 8'h00; 1 pop.
- 200 words, counter_th=100, MAX_WORDS=96 -> two back-to-back frames of N=96 (1456 bytes each); 192 pops; 8 words remain.
- tready toggled pseudo-randomly, N=2 -> byte sequence identical to the tready=1 case; tdata stable across every stall; 60 bytes total.
- reset asserted at byte 20 of an N=5 frame -> tvalid=0 the next cycle; 0 further pops; frame_count=0; a new frame starts cleanly afterwards.
- data_tran_stop=1 with FIFO above threshold -> no frame starts; released mid-frame -> that frame completes normally.
